// File: rtl/clangpu_fetch_unit.sv
// ----------------------------------------------------------------------------
// clangpu_fetch_unit
//   Instruction-fetch front end. A CEXEC pulse fetches CLEN words starting at
//   CMEM_ADDR using AXI4 INCR read bursts (one burst in flight at a time).
//   Words land in a prefetch FIFO that feeds the execute stage through a
//   first-word-fall-through valid/ready stream.
//
// Ports
//   CCLK, CRST          clock, asynchronous active-high reset
//   CEXEC               start pulse (honoured only while idle)
//   CMEM_ADDR, CLEN     start byte address (burst aligned), word count
//   CSTAT, CDONE, CERR  busy, one-cycle done pulse, sticky error
//   M_AXI_AR*           read address channel (master side)
//   M_AXI_R*            read data channel (master side)
//   INST_DATA/VALID     FIFO head and non-empty flag
//   INST_READY          consumer pop
// ----------------------------------------------------------------------------
module clangpu_fetch_unit #(
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int C_BURST_LEN        = 4,
   parameter int C_FIFO_DEPTH       = 16
) (
   input  logic                          CCLK,
   input  logic                          CRST,
   input  logic                          CEXEC,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] CMEM_ADDR,
   input  logic [15:0]                   CLEN,
   output logic                          CSTAT,
   output logic                          CDONE,
   output logic                          CERR,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
   output logic [7:0]                    M_AXI_ARLEN,
   output logic [2:0]                    M_AXI_ARSIZE,
   output logic [1:0]                    M_AXI_ARBURST,
   output logic [3:0]                    M_AXI_ARCACHE,
   output logic                          M_AXI_ARVALID,
   input  logic                          M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
   input  logic [1:0]                    M_AXI_RRESP,
   input  logic                          M_AXI_RLAST,
   input  logic                          M_AXI_RVALID,
   output logic                          M_AXI_RREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0] INST_DATA,
   output logic                          INST_VALID,
   input  logic                          INST_READY
);

   localparam int AW     = C_M_AXI_ADDR_WIDTH;
   localparam int DW     = C_M_AXI_DATA_WIDTH;
   localparam int BSHIFT = $clog2(DW / 8);
   localparam int PW     = $clog2(C_FIFO_DEPTH);
   localparam int CW     = PW + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ADDR  = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [AW-1:0] addr_q,  addr_d;
   logic [15:0]   rem_q,   rem_d;    // words not yet requested
   logic [4:0]    beat_q,  beat_d;   // beats still due in the current burst
   logic          err_q,   err_d;
   logic          done_q,  done_d;

   logic [DW-1:0] mem_q [C_FIFO_DEPTH];
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] cnt_q,  cnt_d;

   logic [15:0] beats;
   logic [15:0] space;
   logic        r_fire, last_exp, bad, push, pop, flush;

   // ---------------------------------------------------------------- AR side
   assign beats = (rem_q < 16'(C_BURST_LEN)) ? rem_q : 16'(C_BURST_LEN);
   assign space = 16'(C_FIFO_DEPTH) - 16'(cnt_q);

   // Space is reserved before the request goes out so R never stalls on the
   // FIFO. While in ADDR the count can only fall, so ARVALID cannot drop
   // before its handshake, and addr_q/rem_q keep ARADDR/ARLEN stable.
   assign M_AXI_ARVALID = (state_q == S_ADDR) && (space >= beats);
   assign M_AXI_ARADDR  = addr_q;
   assign M_AXI_ARLEN   = 8'(beats - 16'd1);
   assign M_AXI_ARSIZE  = 3'(BSHIFT);
   assign M_AXI_ARBURST = 2'b01;
   assign M_AXI_ARCACHE = 4'b0011;

   // ----------------------------------------------------------------- R side
   assign M_AXI_RREADY = (state_q == S_DATA);
   assign r_fire       = M_AXI_RVALID && M_AXI_RREADY;
   assign last_exp     = (beat_q == 5'd1);
   // RLAST must coincide exactly with the expected final beat.
   assign bad          = (M_AXI_RRESP != 2'b00) || (M_AXI_RLAST != last_exp);

   assign pop = INST_READY && (cnt_q != '0);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      beat_d  = beat_q;
      err_d   = err_q;
      done_d  = 1'b0;
      push    = 1'b0;
      flush   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (CEXEC) begin
               err_d  = 1'b0;
               addr_d = CMEM_ADDR;
               rem_d  = CLEN;
               if (CLEN == 16'd0) done_d  = 1'b1;
               else               state_d = S_ADDR;
            end
         end
         S_ADDR: begin
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin
               addr_d  = addr_q + (AW'(beats) << BSHIFT);
               rem_d   = rem_q - beats;
               beat_d  = 5'(beats);
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (r_fire) begin
               beat_d = beat_q - 5'd1;
               if (err_q || bad) begin
                  // Once broken, the rest of the burst is swallowed and the
                  // fetch is abandoned at the end of the slave's burst.
                  err_d = 1'b1;
                  flush = 1'b1;
                  if (last_exp || M_AXI_RLAST) state_d = S_IDLE;
               end else begin
                  push = 1'b1;
                  if (last_exp) state_d = (rem_q != 16'd0) ? S_ADDR : S_DRAIN;
               end
            end
         end
         default: begin // S_DRAIN
            if (cnt_q == '0) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
      endcase
   end

   // ------------------------------------------------------------------- FIFO
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (flush) begin
         wptr_d = '0;
         rptr_d = '0;
         cnt_d  = '0;
      end else begin
         if (push) wptr_d = wptr_q + PW'(1);
         if (pop)  rptr_d = rptr_q + PW'(1);
         cnt_d = cnt_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge CCLK or posedge CRST) begin
      if (CRST) begin
         for (int i = 0; i < C_FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else if (push) begin
         mem_q[wptr_q] <= M_AXI_RDATA;
      end
   end

   always_ff @(posedge CCLK or posedge CRST) begin
      if (CRST) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         beat_q  <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         beat_q  <= beat_d;
         err_q   <= err_d;
         done_q  <= done_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign INST_DATA  = mem_q[rptr_q];
   assign INST_VALID = (cnt_q != '0);
   assign CSTAT      = (state_q != S_IDLE);
   assign CDONE      = done_q;
   assign CERR       = err_q;

endmodule

// File: tb/tb_clangpu_fetch_unit.sv
module tb_clangpu_fetch_unit;

   localparam logic [31:0] K = 32'h5A5A_0000; // slave data = address ^ K

   logic        CCLK, CRST, CEXEC;
   logic [31:0] CMEM_ADDR;
   logic [15:0] CLEN;
   logic        CSTAT, CDONE, CERR;
   logic [31:0] ARADDR;
   logic [7:0]  ARLEN;
   logic [2:0]  ARSIZE;
   logic [1:0]  ARBURST;
   logic [3:0]  ARCACHE;
   logic        ARVALID, ARREADY;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RLAST, RVALID, RREADY;
   logic [31:0] INST_DATA;
   logic        INST_VALID, INST_READY;

   clangpu_fetch_unit #(
      .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32),
      .C_BURST_LEN(4), .C_FIFO_DEPTH(8)
   ) dut (
      .CCLK(CCLK), .CRST(CRST), .CEXEC(CEXEC), .CMEM_ADDR(CMEM_ADDR), .CLEN(CLEN),
      .CSTAT(CSTAT), .CDONE(CDONE), .CERR(CERR),
      .M_AXI_ARADDR(ARADDR), .M_AXI_ARLEN(ARLEN), .M_AXI_ARSIZE(ARSIZE),
      .M_AXI_ARBURST(ARBURST), .M_AXI_ARCACHE(ARCACHE),
      .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
      .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RLAST(RLAST),
      .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY),
      .INST_DATA(INST_DATA), .INST_VALID(INST_VALID), .INST_READY(INST_READY)
   );

   initial CCLK = 1'b0;
   always #5 CCLK = ~CCLK;

   int n_cmp = 0;
   int n_mis = 0;

   // activity logs filled by the slave/monitor process
   logic [31:0] ar_addr_log [8];
   logic [7:0]  ar_len_log  [8];
   logic [31:0] pop_log     [32];
   int          rise_pops   [8];
   int ar_n, pop_n, done_n, rise_n, r_n, arv_hi_n, cyc, done_cyc, last_pop_cyc;
   bit arv_prev;

   // slave state
   bit          err_inject;
   int          err_idx;
   bit          s_busy;
   logic [31:0] s_addr;
   int          s_left, s_idx, s_burst;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      ar_n = 0; pop_n = 0; done_n = 0; rise_n = 0; r_n = 0; arv_hi_n = 0;
      s_burst = 0; arv_prev = 1'b0;
   endtask

   task automatic exec(input logic [31:0] a, input logic [15:0] n);
      @(negedge CCLK); CEXEC = 1'b1; CMEM_ADDR = a; CLEN = n;
      @(negedge CCLK); CEXEC = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      bit ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge CCLK); #4;
         if (!CSTAT) begin ok = 1'b1; break; end
      end
      check({tag, " idle"}, 32'(ok), 32'd1);
   endtask

   // AXI read slave + monitor. Handshakes are sampled 2 time units after the
   // falling edge (values seen by the next rising edge); the slave updates
   // its drives 1 unit after the rising edge.
   initial begin : slave
      bit ar_f, r_f;
      logic [31:0] cap_addr;
      logic [7:0]  cap_len;
      ARREADY = 0; RVALID = 0; RLAST = 0; RRESP = 0; RDATA = 0;
      s_busy = 0; s_addr = 0; s_left = 0; s_idx = 0;
      forever begin
         @(negedge CCLK); #2;
         cyc++;
         ar_f = ARVALID && ARREADY;
         r_f  = RVALID && RREADY;
         cap_addr = ARADDR; cap_len = ARLEN;
         if (ARVALID && !arv_prev && rise_n < 8) begin rise_pops[rise_n] = pop_n; rise_n++; end
         arv_prev = ARVALID;
         if (ARVALID) arv_hi_n++;
         if (ar_f && ar_n < 8) begin ar_addr_log[ar_n] = ARADDR; ar_len_log[ar_n] = ARLEN; ar_n++; end
         if (r_f) r_n++;
         if (INST_VALID && INST_READY) begin
            if (pop_n < 32) pop_log[pop_n] = INST_DATA;
            pop_n++; last_pop_cyc = cyc;
         end
         if (CDONE) begin done_n++; done_cyc = cyc; end
         @(posedge CCLK); #1;
         if (CRST) begin
            ARREADY = 0; RVALID = 0; RLAST = 0; RRESP = 0; s_busy = 0;
         end else begin
            if (r_f) begin
               s_addr = s_addr + 32'd4; s_left--; s_idx++;
               if (s_left == 0) s_busy = 0;
            end
            if (ar_f) begin
               ARREADY = 0; s_busy = 1; s_addr = cap_addr;
               s_left = int'(cap_len) + 1; s_idx = 0; s_burst++;
            end else if (!s_busy && ARVALID && !ARREADY) begin
               ARREADY = 1;
            end
            RVALID = s_busy;
            RDATA  = s_addr ^ K;
            RLAST  = s_busy && (s_left == 1);
            RRESP  = (err_inject && s_busy && s_burst == 1 && s_idx == err_idx) ? 2'b10 : 2'b00;
         end
      end
   end

   initial begin : stim
      bit got;
      CRST = 0; CEXEC = 0; CMEM_ADDR = 0; CLEN = 0; INST_READY = 0;
      err_inject = 0; err_idx = 1;
      clr();
      #1 CRST = 1;

      // ---------------- reset state
      @(negedge CCLK); #4;
      check("rst CSTAT", 32'(CSTAT), 0);
      check("rst CDONE", 32'(CDONE), 0);
      check("rst CERR", 32'(CERR), 0);
      check("rst ARVALID", 32'(ARVALID), 0);
      check("rst RREADY", 32'(RREADY), 0);
      check("rst INST_VALID", 32'(INST_VALID), 0);
      check("rst ARBURST", 32'(ARBURST), 32'h1);
      check("rst ARSIZE", 32'(ARSIZE), 32'h2);
      check("rst ARCACHE", 32'(ARCACHE), 32'h3);
      @(negedge CCLK); CRST = 0;

      // ---------------- 10-word fetch, consumer always ready
      INST_READY = 1; clr();
      exec(32'h1000_0000, 16'd10);
      #4 check("t1 CSTAT busy", 32'(CSTAT), 1);
      wait_idle("t1", 200);
      check("t1 ar count", 32'(ar_n), 3);
      check("t1 ar0 addr", ar_addr_log[0], 32'h1000_0000);
      check("t1 ar0 len", 32'(ar_len_log[0]), 3);
      check("t1 ar1 addr", ar_addr_log[1], 32'h1000_0010);
      check("t1 ar1 len", 32'(ar_len_log[1]), 3);
      check("t1 ar2 addr", ar_addr_log[2], 32'h1000_0020);
      check("t1 ar2 len", 32'(ar_len_log[2]), 1);
      check("t1 pops", 32'(pop_n), 10);
      for (int k = 0; k < 10; k++) check("t1 word", pop_log[k], 32'h4A5A_0000 + 32'(4 * k));
      check("t1 done pulses", 32'(done_n), 1);
      check("t1 done after last pop", 32'(done_cyc > last_pop_cyc), 1);
      check("t1 CERR", 32'(CERR), 0);

      // ---------------- back-pressure with an 8-entry FIFO
      INST_READY = 0; clr();
      exec(32'h2000_0000, 16'd16);
      repeat (40) @(negedge CCLK);
      #4;
      check("t2 ar count stalled", 32'(ar_n), 2);
      check("t2 ARVALID stalled", 32'(ARVALID), 0);
      check("t2 INST_VALID", 32'(INST_VALID), 1);
      check("t2 first word", INST_DATA, 32'h7A5A_0000);
      @(negedge CCLK); INST_READY = 1;
      wait_idle("t2", 300);
      check("t2 rise0 pops", 32'(rise_pops[0]), 0);
      check("t2 rise1 pops", 32'(rise_pops[1]), 0);
      check("t2 rise2 pops", 32'(rise_pops[2]), 4);
      check("t2 ar count", 32'(ar_n), 4);
      check("t2 ar3 addr", ar_addr_log[3], 32'h2000_0030);
      check("t2 pops", 32'(pop_n), 16);
      check("t2 last word", pop_log[15], 32'h7A5A_003C);
      check("t2 done pulses", 32'(done_n), 1);

      // ---------------- SLVERR on beat 2 of the first burst
      INST_READY = 0; clr(); err_inject = 1; err_idx = 1;
      exec(32'h3000_0000, 16'd12);
      wait_idle("t3", 200);
      repeat (10) @(negedge CCLK);
      #4;
      check("t3 CERR", 32'(CERR), 1);
      check("t3 INST_VALID", 32'(INST_VALID), 0);
      check("t3 beats taken", 32'(r_n), 4);
      check("t3 RREADY", 32'(RREADY), 0);
      check("t3 ar count", 32'(ar_n), 1);
      check("t3 no done", 32'(done_n), 0);
      err_inject = 0; INST_READY = 1; clr();
      exec(32'h3000_0000, 16'd4);
      #4 check("t3 CERR cleared", 32'(CERR), 0);
      wait_idle("t3 retry", 200);
      check("t3 retry pops", 32'(pop_n), 4);
      check("t3 retry word0", pop_log[0], 32'h6A5A_0000);
      check("t3 retry done", 32'(done_n), 1);
      check("t3 retry CERR", 32'(CERR), 0);

      // ---------------- CLEN = 0
      clr();
      exec(32'h0000_1000, 16'd0);
      #2;
      check("t4 CDONE pulse", 32'(CDONE), 1);
      check("t4 CSTAT", 32'(CSTAT), 0);
      @(negedge CCLK); #4;
      check("t4 CDONE low", 32'(CDONE), 0);
      repeat (5) @(negedge CCLK);
      check("t4 ARVALID never", 32'(arv_hi_n), 0);
      check("t4 ar count", 32'(ar_n), 0);

      // ---------------- CEXEC re-pulse mid-fetch is ignored
      clr();
      exec(32'h4000_0000, 16'd8);
      repeat (2) @(negedge CCLK);
      exec(32'h5000_0000, 16'd8);
      wait_idle("t5", 200);
      check("t5 ar count", 32'(ar_n), 2);
      check("t5 ar0 addr", ar_addr_log[0], 32'h4000_0000);
      check("t5 ar1 addr", ar_addr_log[1], 32'h4000_0010);
      check("t5 pops", 32'(pop_n), 8);
      check("t5 last word", pop_log[7], 32'h1A5A_001C);
      check("t5 done pulses", 32'(done_n), 1);

      // ---------------- reset while beats stream
      INST_READY = 0; clr();
      exec(32'h6000_0000, 16'd8);
      got = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge CCLK);
         if (r_n >= 2) begin got = 1; break; end
      end
      check("t6 beats seen", 32'(got), 1);
      #1 CRST = 1;
      #1;
      check("t6 CSTAT", 32'(CSTAT), 0);
      check("t6 CDONE", 32'(CDONE), 0);
      check("t6 CERR", 32'(CERR), 0);
      check("t6 ARVALID", 32'(ARVALID), 0);
      check("t6 RREADY", 32'(RREADY), 0);
      check("t6 INST_VALID", 32'(INST_VALID), 0);
      @(negedge CCLK); CRST = 0;
      INST_READY = 1; clr();
      exec(32'h7000_0000, 16'd5);
      wait_idle("t6 after", 200);
      check("t6 ar count", 32'(ar_n), 2);
      check("t6 ar1 len", 32'(ar_len_log[1]), 0);
      check("t6 pops", 32'(pop_n), 5);
      check("t6 last word", pop_log[4], 32'h2A5A_0010);
      check("t6 done", 32'(done_n), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
